ls161: RTL and testbench

- Models the SN74LS161A synchronous 4-bit binary counter with parallel load, count enables and ripple-carry output.
- Sits directly upstream of the dual 4-to-1 multiplexer stage: QA/QB drive the mux A/B selects, so one counter scans the four data inputs in order.
- Cascadable through ENT/RCO to build 8/12/16-bit video and timing counters, with no extra glue logic.

---
 rtl/ls_pkg.sv | 27 ++
 rtl/ls161_stage.sv | 41 ++++
 rtl/ls161.sv | 103 ++++++++++
 tb/tb_ls161.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/ls_pkg.sv
// ---------------------------------------------------------------------------
// ls_pkg
// Shared types and constants for the LS16x / LS19x counter family models.
//
// Contents:
//   nibble_t   - 4-bit counter value
//   NIBBLE_MAX - terminal count of a 4-bit binary stage (drives ripple carry)
//   ctr_op_t   - per-edge operation selected by the control pins
//
// Macros: none (LS161_SYNC_CLR_EN is consumed by ls161.sv only).
// ---------------------------------------------------------------------------
package ls_pkg;

  typedef logic [3:0] nibble_t;

  localparam nibble_t NIBBLE_MAX = 4'hF;

  // What the counter does on the next rising clock edge. Async clears are
  // not represented here; they bypass the clocked path entirely.
  typedef enum logic [1:0] {
    OP_HOLD  = 2'd0,
    OP_LOAD  = 2'd1,
    OP_COUNT = 2'd2,
    OP_CLR   = 2'd3
  } ctr_op_t;

endpackage : ls_pkg

// File: rtl/ls161_stage.sv
// ---------------------------------------------------------------------------
// ls161_stage
// One bit cell of the LS161 counter: a toggle flip-flop with synchronous
// load and synchronous clear, plus an asynchronous clear to RST_BIT.
//
// Parameters:
//   RST_BIT   - value this bit takes on any clear
// Ports:
//   clk       - rising-edge clock
//   rst       - asynchronous clear, active-high (reset and/or async _CLR)
//   clr       - synchronous clear, active-high (highest clocked priority)
//   load      - synchronous parallel load, active-high
//   load_data - bit captured on load
//   toggle    - invert the bit on this edge (carry-in from lower bits)
//   q         - bit value
// ---------------------------------------------------------------------------
module ls161_stage #(
  parameter logic RST_BIT = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic load,
  input  logic load_data,
  input  logic toggle,
  output logic q
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q <= RST_BIT;
    end else if (clr) begin
      q <= RST_BIT;
    end else if (load) begin
      q <= load_data;
    end else if (toggle) begin
      q <= ~q;
    end
  end

endmodule : ls161_stage

// File: rtl/ls161.sv
// ---------------------------------------------------------------------------
// ls161
// SN74LS161A-style synchronous 4-bit binary counter with parallel load,
// two count enables and ripple carry out. QA/QB are intended to drive the
// select lines of a downstream dual 4-to-1 mux; ENT/RCO chain stages into
// wider synchronous counters with no glue.
//
// Parameters:
//   RST_VAL - value forced by _RST and by _CLR
// Ports:
//   _CLK        - clock, all non-async state changes on rising edge
//   _RST        - asynchronous reset, active-high
//   _CLR        - chip clear, active-low (async, or sync with macro below)
//   _LOAD       - synchronous parallel load, active-low
//   _ENP, _ENT  - count enables, active-high; _ENT also gates _RCO
//   _A.._D      - load data, _A is the LSB
//   _QA.._QD    - count outputs, _QA is the LSB
//   _RCO        - ripple carry out = _ENT & (Q == 15)
//
// Build option:
//   LS161_SYNC_CLR_EN - when defined, _CLR acts synchronously with top
//                       clocked priority (LS163 behaviour); _RST stays async.
// ---------------------------------------------------------------------------
module ls161
  import ls_pkg::*;
#(
  parameter nibble_t RST_VAL = 4'h0
) (
  input  logic _CLK,
  input  logic _RST,
  input  logic _CLR,
  input  logic _LOAD,
  input  logic _ENP,
  input  logic _ENT,
  input  logic _A,
  input  logic _B,
  input  logic _C,
  input  logic _D,
  output logic _QA,
  output logic _QB,
  output logic _QC,
  output logic _QD,
  output logic _RCO
);

  nibble_t    q;
  nibble_t    load_data;
  nibble_t    toggle;
  ctr_op_t    op;
  logic       arst;
  logic       sclr;

  assign load_data = {_D, _C, _B, _A};

`ifdef LS161_SYNC_CLR_EN
  assign arst = _RST;
  assign sclr = ~_CLR;
`else
  // Both clears share the flops' async input; either one forces RST_VAL.
  assign arst = _RST | ~_CLR;
  assign sclr = 1'b0;
`endif

  always_comb begin
    op = OP_HOLD;
    if (sclr) begin
      op = OP_CLR;
    end else if (!_LOAD) begin
      op = OP_LOAD;
    end else if (_ENP && _ENT) begin
      op = OP_COUNT;
    end
  end

  // Bit i toggles when counting and every lower bit is 1 (binary carry).
  always_comb begin
    toggle    = '0;
    toggle[0] = (op == OP_COUNT);
    for (int i = 1; i < 4; i++) begin
      toggle[i] = toggle[i-1] & q[i-1];
    end
  end

  for (genvar i = 0; i < 4; i++) begin : g_stage
    ls161_stage #(
      .RST_BIT (RST_VAL[i])
    ) u_stage (
      .clk       (_CLK),
      .rst       (arst),
      .clr       (op == OP_CLR),
      .load      (op == OP_LOAD),
      .load_data (load_data[i]),
      .toggle    (toggle[i]),
      .q         (q[i])
    );
  end

  assign {_QD, _QC, _QB, _QA} = q;

  // Decoded purely from Q and _ENT, so _ENP/_LOAD activity never reaches it.
  assign _RCO = _ENT & (q == NIBBLE_MAX);

endmodule : ls161

// File: tb/tb_ls161.sv
// ---------------------------------------------------------------------------
// tb_ls161
// Self-checking bench for ls161: a single counter plus a two-stage 8-bit
// cascade. An arithmetic reference model is updated by the driver at each
// rising edge (and on async clears); a compare process checks every falling
// edge, and directed steps add literal expectations.
// ---------------------------------------------------------------------------
module tb_ls161;

  localparam logic [3:0] RST_V = 4'h0;

  logic clk = 1'b0;
  logic rst, clr_n, load_n, enp, ent;
  logic [3:0] d;
  logic qa, qb, qc, qd, rco;

  logic cas_load_n, cas_en;
  logic [7:0] cas_d;
  logic cas_clr_n;
  logic lo_qa, lo_qb, lo_qc, lo_qd, lo_rco;
  logic hi_qa, hi_qb, hi_qc, hi_qd, hi_rco;

  int exp_q;
  int exp8;
  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  ls161 dut (
    ._CLK(clk), ._RST(rst), ._CLR(clr_n), ._LOAD(load_n),
    ._ENP(enp), ._ENT(ent),
    ._A(d[0]), ._B(d[1]), ._C(d[2]), ._D(d[3]),
    ._QA(qa), ._QB(qb), ._QC(qc), ._QD(qd), ._RCO(rco)
  );

  ls161 cas_lo (
    ._CLK(clk), ._RST(rst), ._CLR(cas_clr_n), ._LOAD(cas_load_n),
    ._ENP(cas_en), ._ENT(cas_en),
    ._A(cas_d[0]), ._B(cas_d[1]), ._C(cas_d[2]), ._D(cas_d[3]),
    ._QA(lo_qa), ._QB(lo_qb), ._QC(lo_qc), ._QD(lo_qd), ._RCO(lo_rco)
  );

  ls161 cas_hi (
    ._CLK(clk), ._RST(rst), ._CLR(cas_clr_n), ._LOAD(cas_load_n),
    ._ENP(cas_en), ._ENT(lo_rco),
    ._A(cas_d[4]), ._B(cas_d[5]), ._C(cas_d[6]), ._D(cas_d[7]),
    ._QA(hi_qa), ._QB(hi_qb), ._QC(hi_qc), ._QD(hi_qd), ._RCO(hi_rco)
  );

  wire [3:0] q_dut = {qd, qc, qb, qa};
  wire [7:0] q_cas = {hi_qd, hi_qc, hi_qb, hi_qa, lo_qd, lo_qc, lo_qb, lo_qa};

  task automatic chk(input string name, input logic [7:0] got, input logic [7:0] want);
    n_chk++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, want, $time);
    end
  endtask

  // Reference model: what one rising edge does, from the pin rules.
  task automatic edge_model();
    if (rst) begin
      exp_q = RST_V;
      exp8  = 0;
    end else begin
      if (!clr_n)        exp_q = RST_V;
      else if (!load_n)  exp_q = d;
      else if (enp && ent) exp_q = (exp_q + 1) % 16;
      if (!cas_load_n)   exp8 = cas_d;
      else if (cas_en)   exp8 = (exp8 + 1) % 256;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    edge_model();
    @(negedge clk);
    #1;
  endtask

  task automatic set_rst(input logic v);
    rst = v;
    if (v) begin
      exp_q = RST_V;
      exp8  = 0;
    end
  endtask

  task automatic set_clr(input logic v);
    clr_n = v;
`ifndef LS161_SYNC_CLR_EN
    if (!v) exp_q = RST_V;
`endif
  endtask

  always @(negedge clk) begin
    chk("q", {4'h0, q_dut}, exp_q[7:0]);
    chk("rco", {7'h0, rco}, {7'h0, (ent && exp_q == 15)});
    chk("cas_q", q_cas, exp8[7:0]);
    chk("cas_rco", {7'h0, hi_rco}, {7'h0, (cas_en && exp8 == 255)});
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not end, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; clr_n = 1'b1; load_n = 1'b1; enp = 1'b0; ent = 1'b0; d = 4'h0;
    cas_load_n = 1'b1; cas_en = 1'b0; cas_d = 8'h00; cas_clr_n = 1'b1;
    exp_q = RST_V; exp8 = 0;
    #1;
    chk("reset_async", {4'h0, q_dut}, 8'h00);
    @(negedge clk); #1;
    tick();
    chk("reset_hold", {4'h0, q_dut}, 8'h00);

    // Release: first edge with _RST low counts.
    set_rst(1'b0); enp = 1'b1; ent = 1'b1;
    tick();
    chk("rst_release_first", {4'h0, q_dut}, 8'h01);
    for (int i = 0; i < 8; i++) tick();
    chk("count_to_9", {4'h0, q_dut}, 8'h09);

    // Reset mid-count, between edges.
    set_rst(1'b1);
    #1;
    chk("rst_mid_count", {4'h0, q_dut}, 8'h00);
    tick();
    set_rst(1'b0);
    tick();
    chk("rst_rel_again", {4'h0, q_dut}, 8'h01);

    // Free count from 0 for 17 edges.
    set_rst(1'b1); #1; set_rst(1'b0);
    for (int i = 1; i <= 17; i++) begin
      tick();
      if (i == 15) begin
        chk("free_15", {4'h0, q_dut}, 8'h0F);
        chk("free_rco15", {7'h0, rco}, 8'h01);
      end
      if (i == 16) begin
        chk("free_wrap", {4'h0, q_dut}, 8'h00);
        chk("free_rco0", {7'h0, rco}, 8'h00);
      end
    end
    chk("free_17", {4'h0, q_dut}, 8'h01);

    // Load 1101 with enables high: no increment that cycle.
    d = 4'b1101; load_n = 1'b0;
    tick();
    chk("load_13", {4'h0, q_dut}, 8'h0D);

    // Load 15: RCO rises in the same cycle; then load over Q=15 with enables.
    d = 4'hF;
    tick();
    chk("load_15", {4'h0, q_dut}, 8'h0F);
    chk("load_15_rco", {7'h0, rco}, 8'h01);
    d = 4'h3;
    tick();
    chk("load_beats_wrap", {4'h0, q_dut}, 8'h03);

    // Enables at Q=15.
    d = 4'hF;
    tick();
    load_n = 1'b1; enp = 1'b0; ent = 1'b1;
    tick();
    chk("enp_low_hold", {4'h0, q_dut}, 8'h0F);
    chk("enp_low_rco", {7'h0, rco}, 8'h01);
    ent = 1'b0;
    #1;
    chk("ent_low_rco", {7'h0, rco}, 8'h00);
    enp = 1'b1;
    tick();
    chk("ent_low_hold", {4'h0, q_dut}, 8'h0F);

    // Clear pulse between edges at Q=6.
    d = 4'h6; load_n = 1'b0;
    tick();
    load_n = 1'b1; enp = 1'b0; ent = 1'b0;
    set_clr(1'b0);
    #1;
`ifdef LS161_SYNC_CLR_EN
    chk("clr_between_edges", {4'h0, q_dut}, 8'h06);
`else
    chk("clr_between_edges", {4'h0, q_dut}, 8'h00);
`endif
    // Clear held over an edge beats a pending load and count.
    load_n = 1'b0; d = 4'h9; enp = 1'b1; ent = 1'b1;
    tick();
    chk("clr_over_edge", {4'h0, q_dut}, 8'h00);
    set_clr(1'b1); load_n = 1'b1;
    tick();
    chk("clr_release", {4'h0, q_dut}, 8'h01);

    // Both clears together.
    set_rst(1'b1); set_clr(1'b0);
    #1;
    chk("rst_and_clr", {4'h0, q_dut}, 8'h00);
    tick();
    set_rst(1'b0); set_clr(1'b1);
    enp = 1'b0; ent = 1'b0;
    tick();

    // Cascade: 8-bit from 0E, three edges -> 0F, 10, 11.
    cas_d = 8'h0E; cas_load_n = 1'b0;
    tick();
    chk("cas_load", q_cas, 8'h0E);
    cas_load_n = 1'b1; cas_en = 1'b1;
    tick();
    chk("cas_0f", q_cas, 8'h0F);
    tick();
    chk("cas_10", q_cas, 8'h10);
    tick();
    chk("cas_11", q_cas, 8'h11);

    // Cascade through FF -> 00 with the top carry visible.
    cas_en = 1'b0; cas_d = 8'hFE; cas_load_n = 1'b0;
    tick();
    cas_load_n = 1'b1; cas_en = 1'b1;
    tick();
    chk("cas_ff", q_cas, 8'hFF);
    chk("cas_ff_rco", {7'h0, hi_rco}, 8'h01);
    tick();
    chk("cas_wrap", q_cas, 8'h00);
    cas_en = 1'b0;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule : tb_ls161
